dmem_responder: RTL and testbench

//  Memory-side responder for the LSQ<->memory request interface (addr/data/rw/id/valid in; data/id/ready/stall out).

---
 rtl/dmem_responder_pkg.sv | 26 ++
 rtl/dmem_req_fifo.sv | 64 ++++++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the LSQ-facing memory responder.
// Request entries carry the full word address; the responder uses only its low AW bits.
package dmem_responder_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int LSQ_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int WADDR_W  = 30;

  typedef struct packed {
    logic [WADDR_W-1:0]  waddr;
    logic [DATA_W-1:0]   data;
    logic                rw;
    logic [LSQ_ID_W-1:0] id;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } eng_state_t;

endpackage

// File: rtl/dmem_req_fifo.sv
// In-order request queue: DEPTH entries, registered count, no write-to-read bypass.
// Pushes while full and pops while empty are ignored.
module dmem_req_fifo
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  req_t                     push_data,
  input  logic                     pop,
  output req_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: queues LSQ requests and services them one at a time against
// a word array, answering each after LATENCY cycles with the requester's id.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  parameter int AW      = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         addr_in,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                rw_in,
  input  logic [LSQ_ID_W-1:0] id_in,
  input  logic                valid_in,
  output logic [DATA_W-1:0]   data_out,
  output logic [LSQ_ID_W-1:0] id_out,
  output logic                ready_out,
  output logic                stall_out,
  output logic                overflow
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);

  eng_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [LSQ_ID_W-1:0] id_out_q, id_out_d;
  logic                overflow_q, overflow_d;
  logic                cap_rw_q, cap_rw_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic [LSQ_ID_W-1:0] cap_id_q, cap_id_d;

  req_t                  push_req, head;
  logic                  pop, mem_en, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [AW-1:0]         head_idx;
  logic [DATA_W-1:0]     mem [2**AW];
  logic [DATA_W-1:0]     rd_data_q;
  logic                  unused_ok;

  assign push_req = '{waddr: WADDR_W'(addr_in[AW+1:2]), data: data_in, rw: rw_in, id: id_in};
  assign head_idx = head.waddr[AW-1:0];
  assign unused_ok = ^{addr_in[31:AW+2], addr_in[1:0], head.waddr[WADDR_W-1:AW], fifo_count};

  dmem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (valid_in),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    data_out_d = data_out_q;
    id_out_d   = id_out_q;
    cap_rw_d   = cap_rw_q;
    cap_data_d = cap_data_q;
    cap_id_d   = cap_id_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (valid_in & fifo_full);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ready_d    = 1'b1;
          data_out_d = (cap_rw_q == RW_WRITE) ? cap_data_q : rd_data_q;
          id_out_d   = cap_id_q;
          // Back-to-back service: pop the next entry on the same edge as the response.
          if (!fifo_empty) begin
            pop   = 1'b1;
            cnt_d = CNT_RELOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      cap_rw_d   = head.rw;
      cap_data_d = head.data;
      cap_id_d   = head.id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
      id_out_q   <= '0;
      overflow_q <= 1'b0;
      cap_rw_q   <= RW_READ;
      cap_data_q <= '0;
      cap_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
      id_out_q   <= id_out_d;
      overflow_q <= overflow_d;
      cap_rw_q   <= cap_rw_d;
      cap_data_q <= cap_data_d;
      cap_id_q   <= cap_id_d;
    end
  end

  // Array access happens only on a pop outside reset, so a reset edge never commits a store.
  assign mem_en = pop & rst;

  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (head.rw == RW_WRITE) mem[head_idx] <= head.data;
      rd_data_q <= mem[head_idx];
    end
  end

  assign data_out  = data_out_q;
  assign id_out    = id_out_q;
  assign ready_out = ready_q;
  assign stall_out = fifo_full;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected id/data/edge pushed on acceptance,
// popped and compared whenever ready_out pulses.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] data_in = '0;
  logic        rw_in = 1'b0;
  logic [3:0]  id_in = '0;
  logic        valid_in = 1'b0;
  logic [31:0] data_out;
  logic [3:0]  id_out;
  logic        ready_out, stall_out, overflow;

  dmem_responder #(.DEPTH(4), .LATENCY(2), .AW(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .rw_in     (rw_in),
    .id_in     (id_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .id_out    (id_out),
    .ready_out (ready_out),
    .stall_out (stall_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    int          at_edge;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          last_r = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready_out) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", {63'd0, ready_out}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("rsp  edge=%0d id=%0d data=0x%08h (exp edge=%0d id=%0d data=0x%08h)",
                 cyc, id_out, data_out, e.at_edge, e.id, e.data);
        chk("rsp_id", {60'd0, id_out}, {60'd0, e.id});
        chk("rsp_data", {32'd0, data_out}, {32'd0, e.data});
        chk("rsp_edge", 64'(cyc), 64'(e.at_edge));
      end
    end
  end

  // Called #1 after an edge; leaves the bench #1 after the accepting edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] id);
    int   guard;
    int   idx;
    int   s;
    exp_t e;
    guard = 0;
    while (stall_out && guard < 50) begin
      valid_in = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    if (stall_out) chk("stall_stuck", {63'd0, stall_out}, 64'd0);
    addr_in = a; data_in = d; rw_in = w; id_in = id; valid_in = 1'b1;
    @(posedge clk); #1;
    idx = int'(a[11:2]);
    if (w) model[idx] = d;
    e.id   = id;
    e.data = model.exists(idx) ? model[idx] : 32'h0;
    s = (cyc + 1 > last_r) ? cyc + 1 : last_r;
    e.at_edge = s + 2;
    last_r = e.at_edge;
    sb.push_back(e);
    $display("req  edge=%0d %s addr=0x%08h data=0x%08h id=%0d", cyc, w ? "W" : "R", a, d, id);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    valid_in = 1'b0;
    while (sb.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    idle(2);
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  {32'd0, data_out}, 64'd0);
    chk({tag, "_id"},    {60'd0, id_out}, 64'd0);
    chk({tag, "_ready"}, {63'd0, ready_out}, 64'd0);
    chk({tag, "_stall"}, {63'd0, stall_out}, 64'd0);
    chk({tag, "_ovf"},   {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    logic [31:0] addrs [9];
    int t0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    idle(1);

    // Store then load of the same word, back to back.
    issue(RW_WRITE, 32'h10, 32'hDEADBEEF, 4'd3);
    issue(RW_READ,  32'h10, 32'h0, 4'd4);
    drain();

    // Stream of stores until the queue fills.
    t0 = cyc + 1;
    for (int i = 0; i < 7; i++) begin
      issue(RW_WRITE, 32'h200 + 32'(4 * i), 32'hA000 + 32'(i), 4'(i));
      if (i < 6) chk("stall_early", {63'd0, stall_out}, 64'd0);
    end
    chk("stall_full", {63'd0, stall_out}, 64'd1);
    chk("stall_edge", 64'(cyc - t0), 64'd6);
    addr_in = 32'h300; data_in = 32'hBAD; rw_in = RW_WRITE; id_in = 4'd7; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    $display("drop edge=%0d id=7 (stall was high)", cyc);
    chk("overflow_set", {63'd0, overflow}, 64'd1);
    drain();
    chk("overflow_sticky", {63'd0, overflow}, 64'd1);

    // Reset in the middle of a load stream.
    for (int i = 0; i < 4; i++) issue(RW_READ, 32'h200 + 32'(4 * i), 32'h0, 4'(i));
    valid_in = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    last_r = 0;
    $display("rst  edge=%0d queue flushed", cyc);
    chk_reset_outputs("midrst");
    rst = 1'b1;
    idle(10);

    // Address bits above the word index are ignored.
    issue(RW_WRITE, 32'h1004, 32'h55, 4'd5);
    issue(RW_READ,  32'h0004, 32'h0, 4'd6);
    drain();

    // Random mix over words known to the model, with idle gaps.
    addrs[0] = 32'h10; addrs[1] = 32'h4;
    for (int i = 0; i < 7; i++) addrs[i + 2] = 32'h200 + 32'(4 * i);
    for (int i = 0; i < 30; i++) begin
      issue(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 8)], $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
